// File: rtl/sgd_mem_rd_dispatch.sv
`timescale 1ns/1ps
// Dispatches SGD memory read responses: "a" lines into a show-ahead line FIFO, "b" lines into a
// label FIFO unpacked one 32-bit word per handshake, with registered back-pressure toward memory.
module sgd_mem_rd_dispatch #(
  parameter int unsigned A_DEPTH_BITS = 6,
  parameter int unsigned B_DEPTH_BITS = 4,
  parameter int unsigned READY_SLACK  = 4,
  parameter logic [7:0]  MEM_RD_A_TAG = 8'h01,
  parameter logic [7:0]  MEM_RD_B_TAG = 8'h02
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         started,
  input  logic [511:0] um_rx_data,
  input  logic [7:0]   um_rx_rd_tag,
  input  logic         um_rx_rd_valid,
  output logic         um_rx_rd_ready,
  output logic [511:0] a_data,
  output logic         a_valid,
  input  logic         a_ready,
  output logic [31:0]  b_value,
  output logic         b_valid,
  input  logic         b_ready,
  output logic [31:0]  num_rx_a,
  output logic [31:0]  num_rx_b,
  output logic         tag_error
);

  localparam int unsigned ADepth = 1 << A_DEPTH_BITS;
  localparam int unsigned BDepth = 1 << B_DEPTH_BITS;
  localparam logic [A_DEPTH_BITS:0] AFillMax = (A_DEPTH_BITS + 1)'(ADepth - READY_SLACK);
  localparam logic [B_DEPTH_BITS:0] BFillMax = (B_DEPTH_BITS + 1)'(BDepth - READY_SLACK);

  logic [511:0]            a_mem_q [ADepth];
  logic [511:0]            b_mem_q [BDepth];
  logic [A_DEPTH_BITS-1:0] a_wr_ptr_q, a_rd_ptr_q;
  logic [B_DEPTH_BITS-1:0] b_wr_ptr_q, b_rd_ptr_q;
  logic [A_DEPTH_BITS:0]   a_cnt_q, a_cnt_d;
  logic [B_DEPTH_BITS:0]   b_cnt_q, b_cnt_d;
  logic [3:0]              b_word_q;
  logic                    ready_q, ready_d;
  logic [31:0]             num_rx_a_q, num_rx_b_q;
  logic                    tag_error_q;

  logic         accept, a_push, b_push, bad_tag;
  logic         a_pop, b_adv, b_pop;
  logic [511:0] b_head;

  always_comb begin
    accept  = um_rx_rd_valid & ready_q;
    a_push  = accept & (um_rx_rd_tag == MEM_RD_A_TAG);
    b_push  = accept & (um_rx_rd_tag == MEM_RD_B_TAG);
    bad_tag = accept & ~a_push & ~b_push;
    a_pop   = a_valid & a_ready;
    b_adv   = b_valid & b_ready;
    b_pop   = b_adv & (b_word_q == 4'hf);
  end

  // Registered ready: the slack absorbs the write that lands while ready is still high.
  always_comb begin
    ready_d = started & (a_cnt_q <= AFillMax) & (b_cnt_q <= BFillMax);
  end

  always_comb begin
    a_cnt_d = a_cnt_q;
    if (a_push && !a_pop) begin
      a_cnt_d = a_cnt_q + 1'b1;
    end else if (!a_push && a_pop) begin
      a_cnt_d = a_cnt_q - 1'b1;
    end
    b_cnt_d = b_cnt_q;
    if (b_push && !b_pop) begin
      b_cnt_d = b_cnt_q + 1'b1;
    end else if (!b_push && b_pop) begin
      b_cnt_d = b_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b0;
      a_wr_ptr_q  <= '0;
      a_rd_ptr_q  <= '0;
      a_cnt_q     <= '0;
      b_wr_ptr_q  <= '0;
      b_rd_ptr_q  <= '0;
      b_cnt_q     <= '0;
      b_word_q    <= '0;
      num_rx_a_q  <= '0;
      num_rx_b_q  <= '0;
      tag_error_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      if (a_push) begin
        a_wr_ptr_q <= a_wr_ptr_q + 1'b1;
        num_rx_a_q <= num_rx_a_q + 32'd1;
      end
      if (a_pop) begin
        a_rd_ptr_q <= a_rd_ptr_q + 1'b1;
      end
      if (b_push) begin
        b_wr_ptr_q <= b_wr_ptr_q + 1'b1;
        num_rx_b_q <= num_rx_b_q + 32'd1;
      end
      if (b_pop) begin
        b_rd_ptr_q <= b_rd_ptr_q + 1'b1;
      end
      // 4-bit index wraps to word 0 exactly when the line is popped.
      if (b_adv) begin
        b_word_q <= b_word_q + 1'b1;
      end
      if (bad_tag) begin
        tag_error_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (a_push) begin
      a_mem_q[a_wr_ptr_q] <= um_rx_data;
    end
    if (b_push) begin
      b_mem_q[b_wr_ptr_q] <= um_rx_data;
    end
  end

  always_comb begin
    a_valid        = (a_cnt_q != '0);
    b_valid        = (b_cnt_q != '0);
    a_data         = a_valid ? a_mem_q[a_rd_ptr_q] : '0;
    b_head         = b_mem_q[b_rd_ptr_q];
    b_value        = b_valid ? b_head[{b_word_q, 5'd0} +: 32] : '0;
    um_rx_rd_ready = ready_q;
    num_rx_a       = num_rx_a_q;
    num_rx_b       = num_rx_b_q;
    tag_error      = tag_error_q;
  end

endmodule

// File: tb/tb_sgd_mem_rd_dispatch.sv
`timescale 1ns/1ps
// Self-checking bench for sgd_mem_rd_dispatch: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sgd_mem_rd_dispatch;

  localparam logic [7:0] ATag = 8'h01;
  localparam logic [7:0] BTag = 8'h02;

  logic         clk = 1'b0;
  logic         rst;
  logic         started;
  logic [511:0] um_rx_data;
  logic [7:0]   um_rx_rd_tag;
  logic         um_rx_rd_valid;
  logic         um_rx_rd_ready;
  logic [511:0] a_data;
  logic         a_valid;
  logic         a_ready;
  logic [31:0]  b_value;
  logic         b_valid;
  logic         b_ready;
  logic [31:0]  num_rx_a;
  logic [31:0]  num_rx_b;
  logic         tag_error;

  always #5 clk = ~clk;

  sgd_mem_rd_dispatch #(
    .A_DEPTH_BITS(6),
    .B_DEPTH_BITS(4),
    .READY_SLACK (4),
    .MEM_RD_A_TAG(ATag),
    .MEM_RD_B_TAG(BTag)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .started       (started),
    .um_rx_data    (um_rx_data),
    .um_rx_rd_tag  (um_rx_rd_tag),
    .um_rx_rd_valid(um_rx_rd_valid),
    .um_rx_rd_ready(um_rx_rd_ready),
    .a_data        (a_data),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .b_value       (b_value),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .num_rx_a      (num_rx_a),
    .num_rx_b      (num_rx_b),
    .tag_error     (tag_error)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: FIFOs as queues, ready from occupancy before each edge.
  logic [511:0] mq_a[$];
  logic [511:0] mq_b[$];
  int           m_word = 0;
  bit           m_ready = 1'b0;
  bit           m_terr = 1'b0;
  logic [31:0]  m_na = '0;
  logic [31:0]  m_nb = '0;

  always @(posedge clk) begin
    bit acc, apop, badv;
    int afill, bfill;
    afill = mq_a.size();
    bfill = mq_b.size();
    if (rst) begin
      mq_a.delete();
      mq_b.delete();
      m_word  = 0;
      m_ready = 1'b0;
      m_terr  = 1'b0;
      m_na    = '0;
      m_nb    = '0;
    end else begin
      acc     = um_rx_rd_valid && m_ready;
      apop    = (afill > 0) && a_ready;
      badv    = (bfill > 0) && b_ready;
      m_ready = started && (afill <= 64 - 4) && (bfill <= 16 - 4);
      if (apop) void'(mq_a.pop_front());
      if (badv) begin
        if (m_word == 15) begin
          void'(mq_b.pop_front());
          m_word = 0;
        end else begin
          m_word++;
        end
      end
      if (acc) begin
        if (um_rx_rd_tag == ATag) begin
          mq_a.push_back(um_rx_data);
          m_na++;
        end else if (um_rx_rd_tag == BTag) begin
          mq_b.push_back(um_rx_data);
          m_nb++;
        end else begin
          m_terr = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [511:0] ea, hb;
    logic [31:0]  eb;
    if (chk_en) begin
      ea = (mq_a.size() != 0) ? mq_a[0] : '0;
      eb = '0;
      if (mq_b.size() != 0) begin
        hb = mq_b[0];
        eb = hb[m_word*32 +: 32];
      end
      chk("m_ready", um_rx_rd_ready, m_ready);
      chk("m_a_valid", a_valid, mq_a.size() != 0);
      chk("m_a_data", a_data, ea);
      chk("m_b_valid", b_valid, mq_b.size() != 0);
      chk("m_b_value", b_value, eb);
      chk("m_num_rx_a", num_rx_a, m_na);
      chk("m_num_rx_b", num_rx_b, m_nb);
      chk("m_tag_error", tag_error, m_terr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds valid until the line is accepted; leaves valid high for back-to-back sends.
  task automatic send(input logic [7:0] t, input logic [511:0] d);
    bit r;
    bit done;
    done           = 1'b0;
    um_rx_rd_valid = 1'b1;
    um_rx_rd_tag   = t;
    um_rx_data     = d;
    for (int i = 0; i < 200 && !done; i++) begin
      r = um_rx_rd_ready;
      tick();
      done = r;
    end
    chk("send_accepted", done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] bline;
    int acc;
    bit r;
    rst = 1'b1; started = 1'b0; um_rx_data = '0; um_rx_rd_tag = '0; um_rx_rd_valid = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    chk("rst_ready", um_rx_rd_ready, 1'b0);
    chk("rst_a_valid", a_valid, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_num_rx_a", num_rx_a, 32'd0);
    chk("rst_tag_error", tag_error, 1'b0);
    tick();
    rst = 1'b0; started = 1'b1;
    tick(); tick();
    chk("ready_up", um_rx_rd_ready, 1'b1);

    // Three a-lines back to back, consumer always ready.
    a_ready = 1'b1;
    send(ATag, 512'h1); chk("a_seq1", a_data, 512'h1);
    send(ATag, 512'h2); chk("a_seq2", a_data, 512'h2);
    send(ATag, 512'h3); chk("a_seq3", a_data, 512'h3);
    um_rx_rd_valid = 1'b0;
    tick();
    chk("a_seq_empty", a_valid, 1'b0);
    chk("a_seq_count", num_rx_a, 32'd3);

    // One b-line unpacked into 16 labels.
    b_ready = 1'b1;
    for (int i = 0; i < 16; i++) bline[32*i +: 32] = 32'(100 + i);
    send(BTag, bline);
    um_rx_rd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("b_word", b_value, 512'(100 + i));
      tick();
    end
    chk("b_drained", b_valid, 1'b0);
    chk("b_count", num_rx_b, 32'd1);

    // Fill A with consumer stalled: ready must throttle at 62 stored lines.
    a_ready = 1'b0; b_ready = 1'b0;
    um_rx_rd_valid = 1'b1; um_rx_rd_tag = ATag;
    acc = 0;
    for (int k = 0; k < 80; k++) begin
      um_rx_data = 512'(1000 + acc);
      r = um_rx_rd_ready;
      tick();
      if (r) acc++;
    end
    um_rx_rd_valid = 1'b0;
    chk("stream_count", acc, 512'd62);
    chk("stream_ready_low", um_rx_rd_ready, 1'b0);
    a_ready = 1'b1;
    for (int j = 0; j < 62; j++) begin
      chk("stream_order", a_data, 512'(1000 + j));
      tick();
    end
    chk("stream_empty", a_valid, 1'b0);
    chk("stream_num_a", num_rx_a, 32'd65);

    // Unknown tag: dropped, sticky error.
    tick();
    send(8'h55, 512'hdead);
    um_rx_rd_valid = 1'b0;
    chk("bad_tag_err", tag_error, 1'b1);
    chk("bad_tag_num_a", num_rx_a, 32'd65);
    chk("bad_tag_num_b", num_rx_b, 32'd1);
    chk("bad_tag_no_a", a_valid, 1'b0);
    tick(); tick(); tick();
    chk("bad_tag_sticky", tag_error, 1'b1);

    // started dropped mid-run: ready falls, buffered line still drains.
    a_ready = 1'b0;
    send(ATag, 512'h77);
    um_rx_rd_valid = 1'b0;
    started = 1'b0;
    tick();
    chk("stop_ready_low", um_rx_rd_ready, 1'b0);
    chk("stop_a_data", a_data, 512'h77);
    a_ready = 1'b1;
    tick();
    chk("stop_drained", a_valid, 1'b0);
    started = 1'b1;
    tick();

    // Reset with lines buffered in both FIFOs.
    a_ready = 1'b0; b_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(ATag, 512'(500 + i));
    for (int i = 0; i < 2; i++) send(BTag, 512'(900 + i));
    um_rx_rd_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_a_valid", a_valid, 1'b0);
    chk("mid_rst_b_valid", b_valid, 1'b0);
    chk("mid_rst_num_a", num_rx_a, 32'd0);
    chk("mid_rst_num_b", num_rx_b, 32'd0);
    chk("mid_rst_tag_err", tag_error, 1'b0);
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_a_valid", a_valid, 1'b0);
    chk("post_rst_b_valid", b_valid, 1'b0);
    a_ready = 1'b1;
    send(ATag, 512'habc);
    um_rx_rd_valid = 1'b0;
    chk("fresh_a_valid", a_valid, 1'b1);
    chk("fresh_a_data", a_data, 512'habc);
    tick();
    chk("fresh_drained", a_valid, 1'b0);
    chk("fresh_num_a", num_rx_a, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
